alarm_mode_ctrl: RTL
====================

Name: alarm_mode_ctrl

Overview:
Mode sequencer for the math alarm clock. It owns the display-mode flags (alarm_on, question, alarm_set, clock_set), the set-clock/set-alarm editing, alarm match detection and the question/answer loop. It sits between the debounced key pulses, the timekeeper, the question generator and the hex display decoder.

Parameters:
ALARM_HR_RST, 4'd6, alarm hour after reset (1..12)
ALARM_MIN_RST, 6'd0, alarm minute after reset (0..59)
MAX_TRIES, 3, wrong answers allowed before re-ring; counter width is clog2(MAX_TRIES+1)
SNOOZE_SECS, 300, snooze length in sec_tick pulses (only with SNOOZE_EN)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
sec_tick  in  1  one-cycle pulse per second from the timekeeper
key_mode  in  1  debounced one-cycle pulse
key_enter  in  1  debounced one-cycle pulse
key_inc_hr  in  1  debounced one-cycle pulse
key_inc_min  in  1  debounced one-cycle pulse
clock_hr  in  4  live hour, 1..12
clock_min  in  6  live minute, 0..59
answer  in  7  user switches, 0..99
q_valid  in  1  generator operands valid; one-cycle pulse
q_a, q_b  in  7 each  generator operands; generator guarantees q_a+q_b <= 99
q_req  out  1  one-cycle request for a new question
clock_load  out  1  one-cycle pulse: timekeeper loads set_hr/set_min
set_hr, set_min  out  4/6  edited time
alarm_hr, alarm_min  out  4/6  stored alarm time
disp_hr, disp_min  out  4/6  set_hr/set_min in SET_CLOCK, else clock_hr/clock_min
alarm_on, question, alarm_set, clock_set  out  1 each  display-mode flags
question_a, question_b, question_c  out  7 each  captured operands; question_c = answer
buzzer  out  1  alarm sound enable

Behaviour:
- States: RUN, SET_CLOCK, SET_ALARM, RINGING, QUESTION. Flags are a combinational decode of the state register:
  - RUN: clock_set=1.
  - SET_CLOCK: clock_set=1.
  - SET_ALARM: alarm_set=1.
  - RINGING: alarm_on=1, buzzer=1.
  - QUESTION: alarm_on=1, question=1, buzzer=1.
- Reset values:
  - State and flags: state=RUN, so clock_set=1 and alarm_on/question/alarm_set=0. buzzer=0, q_req=0, clock_load=0.
  - Alarm and edit registers: alarm_hr/min=ALARM_HR_RST/ALARM_MIN_RST, armed=0, fired=0, tries=0, set_hr=12, set_min=0.
  - Operands: question_a/b=0.
  - Reset mid-operation aborts any state immediately, including RINGING and QUESTION.
- Key priority in one cycle: key_enter over key_mode. key_inc_hr and key_inc_min may both apply in the same cycle.
- Increment wrap rules: hour 12->1, minute 59->0, no carry from minute into hour.
- RUN:
  - key_mode -> SET_CLOCK; set_hr/set_min load clock_hr/clock_min.
  - Match (armed and fired=0 and clock_hr==alarm_hr and clock_min==alarm_min, sampled on sec_tick) -> RINGING; set fired, tries=0, pulse q_req next cycle.
- fired clears in any state on the first cycle where clock_min != alarm_min, so the alarm rings at most once per match minute.
- SET_CLOCK:
  - Inc keys edit set_hr/set_min.
  - key_enter -> clock_load for 1 cycle, then RUN.
  - key_mode -> SET_ALARM with no load.
- SET_ALARM:
  - Inc keys edit alarm_hr/alarm_min directly.
  - key_enter -> armed=1, then RUN.
  - key_mode -> armed=0, then RUN (disarm path).
- A match that occurs while in SET_CLOCK or SET_ALARM is dropped, not deferred.
- RINGING:
  - Wait for q_valid; capture q_a/q_b into question_a/b, then QUESTION. Latency from q_req to QUESTION = generator latency + 1 cycle.
  - A q_valid that arrives while not in RINGING is ignored.
- QUESTION, on key_enter:
  - Correct (8-bit compare {1'b0,answer} == q_a+q_b): -> RUN, buzzer drops the next cycle.
  - Wrong with tries+1 < MAX_TRIES: tries++, stay in QUESTION.
  - Wrong with tries+1 == MAX_TRIES: tries=0, pulse q_req, go to RINGING (fresh question).
- No timeout: the alarm rings until it is answered.

Optional Feature:
ALARM_SNOOZE_EN
- Defined:
  - Extra state SNOOZE, all flags low except clock_set=1.
  - key_mode in RINGING or QUESTION -> SNOOZE; a counter loads SNOOZE_SECS and decrements on sec_tick.
  - At 0 -> RINGING with q_req; tries is reset.
  - In SNOOZE, key_enter cancels the snooze -> RUN.
- Undefined: key_mode is ignored in RINGING/QUESTION, and no counter exists.

Decomposition:
- Package alarm_pkg: state enum, HR_MIN=1, HR_MAX=12, MIN_MAX=59, ANS_W=7.
- Sub-module hm_wrap_inc: combinational hour/minute increment with wrap. It is instantiated for the set registers and the alarm registers.

Test Plan:
- Reset, then idle 10 cycles -> clock_set=1, other flags 0, alarm 6:00, armed=0.
- key_mode, then key_inc_hr x3 from 11:58 and key_inc_min x3 -> set 2:01; key_enter -> one clock_load pulse with set_hr=2, set_min=1; then RUN.
- Arm alarm at 7:30, clock reaches 7:30 on sec_tick -> RINGING, q_req pulse; q_valid with a=23, b=45 -> question_a=23, question_b=45, question=1.
- In QUESTION with a=23, b=45: answer=68 + key_enter -> RUN and buzzer=0; alarm does not retrigger while clock_min stays 30.
- Three wrong answers (answer=67) -> RINGING with a new q_req; key_mode and key_enter in the same cycle -> enter wins.
- With ALARM_SNOOZE_EN and SNOOZE_SECS=5: key_mode in QUESTION -> SNOOZE; after 5 sec_ticks -> RINGING plus q_req.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types and time-range constants for the math alarm clock mode sequencer.
package alarm_pkg;

  typedef enum logic [2:0] {
    StRun,
    StSetClock,
    StSetAlarm,
    StRinging,
    StQuestion,
    StSnooze
  } state_e;

  localparam logic [3:0] HR_MIN  = 4'd1;
  localparam logic [3:0] HR_MAX  = 4'd12;
  localparam logic [5:0] MIN_MAX = 6'd59;
  localparam int unsigned ANS_W  = 7;

endpackage

// File: rtl/hm_wrap_inc.sv
// Combinational hour/minute increment: hour wraps 12->1, minute wraps 59->0, no carry.
module hm_wrap_inc
  import alarm_pkg::*;
(
  input  logic [3:0] hr,
  input  logic [5:0] min,
  input  logic       inc_hr,
  input  logic       inc_min,
  output logic [3:0] hr_next,
  output logic [5:0] min_next
);

  always_comb begin
    hr_next  = hr;
    min_next = min;
    if (inc_hr) begin
      hr_next = (hr >= HR_MAX) ? HR_MIN : hr + 4'd1;
    end
    if (inc_min) begin
      min_next = (min >= MIN_MAX) ? 6'd0 : min + 6'd1;
    end
  end

endmodule

// File: rtl/alarm_mode_ctrl.sv
// Mode sequencer for the math alarm clock: set-clock/set-alarm editing, alarm match, Q&A loop.
// Optional snooze state is built when ALARM_SNOOZE_EN is defined.
module alarm_mode_ctrl
  import alarm_pkg::*;
#(
  parameter logic [3:0]  ALARM_HR_RST  = 4'd6,
  parameter logic [5:0]  ALARM_MIN_RST = 6'd0,
  parameter int unsigned MAX_TRIES     = 3,
  parameter int unsigned SNOOZE_SECS   = 300
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sec_tick,
  input  logic             key_mode,
  input  logic             key_enter,
  input  logic             key_inc_hr,
  input  logic             key_inc_min,
  input  logic [3:0]       clock_hr,
  input  logic [5:0]       clock_min,
  input  logic [ANS_W-1:0] answer,
  input  logic             q_valid,
  input  logic [ANS_W-1:0] q_a,
  input  logic [ANS_W-1:0] q_b,
  output logic             q_req,
  output logic             clock_load,
  output logic [3:0]       set_hr,
  output logic [5:0]       set_min,
  output logic [3:0]       alarm_hr,
  output logic [5:0]       alarm_min,
  output logic [3:0]       disp_hr,
  output logic [5:0]       disp_min,
  output logic             alarm_on,
  output logic             question,
  output logic             alarm_set,
  output logic             clock_set,
  output logic [ANS_W-1:0] question_a,
  output logic [ANS_W-1:0] question_b,
  output logic [ANS_W-1:0] question_c,
  output logic             buzzer
);

  localparam int unsigned TriesW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES + 1) : 1;
  localparam logic [TriesW-1:0] TriesLast = TriesW'(MAX_TRIES - 1);

  state_e             state_q, state_d;
  logic [3:0]         alarm_hr_q, alarm_hr_d, set_hr_q, set_hr_d;
  logic [5:0]         alarm_min_q, alarm_min_d, set_min_q, set_min_d;
  logic               armed_q, armed_d, fired_q, fired_d;
  logic [TriesW-1:0]  tries_q, tries_d;
  logic [ANS_W-1:0]   qa_q, qa_d, qb_q, qb_d;
  logic               q_req_q, q_req_d, clock_load_q, clock_load_d;
  logic [3:0]         set_hr_inc, alarm_hr_inc;
  logic [5:0]         set_min_inc, alarm_min_inc;
  logic               match, correct;

`ifdef ALARM_SNOOZE_EN
  localparam int unsigned SnzW = (SNOOZE_SECS > 0) ? $clog2(SNOOZE_SECS + 1) : 1;
  logic [SnzW-1:0] snz_q, snz_d;
`else
  logic unused_snooze_secs;
  assign unused_snooze_secs = ^SNOOZE_SECS;
`endif

  hm_wrap_inc u_set_inc (
    .hr       (set_hr_q),
    .min      (set_min_q),
    .inc_hr   (key_inc_hr),
    .inc_min  (key_inc_min),
    .hr_next  (set_hr_inc),
    .min_next (set_min_inc)
  );

  hm_wrap_inc u_alarm_inc (
    .hr       (alarm_hr_q),
    .min      (alarm_min_q),
    .inc_hr   (key_inc_hr),
    .inc_min  (key_inc_min),
    .hr_next  (alarm_hr_inc),
    .min_next (alarm_min_inc)
  );

  assign match = sec_tick & armed_q & ~fired_q &
                 (clock_hr == alarm_hr_q) & (clock_min == alarm_min_q);
  // 8-bit compare so a 7-bit sum cannot alias on overflow
  assign correct = ({1'b0, answer} == ({1'b0, qa_q} + {1'b0, qb_q}));

  always_comb begin
    state_d      = state_q;
    alarm_hr_d   = alarm_hr_q;
    alarm_min_d  = alarm_min_q;
    set_hr_d     = set_hr_q;
    set_min_d    = set_min_q;
    armed_d      = armed_q;
    fired_d      = fired_q;
    tries_d      = tries_q;
    qa_d         = qa_q;
    qb_d         = qb_q;
    q_req_d      = 1'b0;
    clock_load_d = 1'b0;
`ifdef ALARM_SNOOZE_EN
    snz_d        = snz_q;
`endif
    // Re-arms the once-per-minute latch as soon as the minute moves on
    if (clock_min != alarm_min_q) fired_d = 1'b0;

    unique case (state_q)
      StRun: begin
        if (match) begin
          state_d = StRinging;
          fired_d = 1'b1;
          tries_d = '0;
          q_req_d = 1'b1;
        end else if (key_mode) begin
          state_d   = StSetClock;
          set_hr_d  = clock_hr;
          set_min_d = clock_min;
        end
      end
      StSetClock: begin
        set_hr_d  = set_hr_inc;
        set_min_d = set_min_inc;
        if (key_enter) begin
          clock_load_d = 1'b1;
          state_d      = StRun;
        end else if (key_mode) begin
          state_d = StSetAlarm;
        end
      end
      StSetAlarm: begin
        alarm_hr_d  = alarm_hr_inc;
        alarm_min_d = alarm_min_inc;
        if (key_enter) begin
          armed_d = 1'b1;
          state_d = StRun;
        end else if (key_mode) begin
          armed_d = 1'b0;
          state_d = StRun;
        end
      end
      StRinging: begin
        if (q_valid) begin
          qa_d    = q_a;
          qb_d    = q_b;
          state_d = StQuestion;
        end
`ifdef ALARM_SNOOZE_EN
        else if (key_mode) begin
          state_d = StSnooze;
          snz_d   = SnzW'(SNOOZE_SECS);
        end
`endif
      end
      StQuestion: begin
        if (key_enter) begin
          if (correct) begin
            state_d = StRun;
          end else if (tries_q == TriesLast) begin
            tries_d = '0;
            q_req_d = 1'b1;
            state_d = StRinging;
          end else begin
            tries_d = tries_q + 1'b1;
          end
        end
`ifdef ALARM_SNOOZE_EN
        else if (key_mode) begin
          state_d = StSnooze;
          snz_d   = SnzW'(SNOOZE_SECS);
        end
`endif
      end
`ifdef ALARM_SNOOZE_EN
      StSnooze: begin
        if (key_enter) begin
          state_d = StRun;
        end else if (snz_q == '0) begin
          state_d = StRinging;
          tries_d = '0;
          q_req_d = 1'b1;
        end else if (sec_tick) begin
          snz_d = snz_q - 1'b1;
        end
      end
`endif
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StRun;
      alarm_hr_q   <= ALARM_HR_RST;
      alarm_min_q  <= ALARM_MIN_RST;
      set_hr_q     <= HR_MAX;
      set_min_q    <= 6'd0;
      armed_q      <= 1'b0;
      fired_q      <= 1'b0;
      tries_q      <= '0;
      qa_q         <= '0;
      qb_q         <= '0;
      q_req_q      <= 1'b0;
      clock_load_q <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      snz_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      alarm_hr_q   <= alarm_hr_d;
      alarm_min_q  <= alarm_min_d;
      set_hr_q     <= set_hr_d;
      set_min_q    <= set_min_d;
      armed_q      <= armed_d;
      fired_q      <= fired_d;
      tries_q      <= tries_d;
      qa_q         <= qa_d;
      qb_q         <= qb_d;
      q_req_q      <= q_req_d;
      clock_load_q <= clock_load_d;
`ifdef ALARM_SNOOZE_EN
      snz_q        <= snz_d;
`endif
    end
  end

  always_comb begin
    alarm_on  = 1'b0;
    question  = 1'b0;
    alarm_set = 1'b0;
    clock_set = 1'b0;
    buzzer    = 1'b0;
    unique case (state_q)
      StRun, StSetClock, StSnooze: clock_set = 1'b1;
      StSetAlarm: alarm_set = 1'b1;
      StRinging: begin
        alarm_on = 1'b1;
        buzzer   = 1'b1;
      end
      StQuestion: begin
        alarm_on = 1'b1;
        question = 1'b1;
        buzzer   = 1'b1;
      end
      default: clock_set = 1'b1;
    endcase
  end

  assign q_req      = q_req_q;
  assign clock_load = clock_load_q;
  assign set_hr     = set_hr_q;
  assign set_min    = set_min_q;
  assign alarm_hr   = alarm_hr_q;
  assign alarm_min  = alarm_min_q;
  assign disp_hr    = (state_q == StSetClock) ? set_hr_q : clock_hr;
  assign disp_min   = (state_q == StSetClock) ? set_min_q : clock_min;
  assign question_a = qa_q;
  assign question_b = qb_q;
  assign question_c = answer;

endmodule
